// File: rtl/tuner_led_ctrl.sv
// tuner_led_ctrl: drives the 3xTLC5916 tuner LED chain through the
// serial LED interface, with update coalescing and periodic refresh.
module tuner_led_ctrl #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned TUNE_W      = 16,
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned CLK_DIV     = 8,
  parameter int unsigned REFRESH_W   = 20,
  parameter logic [7:0]  BRIGHT_INIT = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [TUNE_W-1:0] tune_i,
  input  logic              tune_wr_i,
  input  logic              blank_i,
  input  logic [7:0]        bright_i,
  input  logic              bright_wr_i,
  input  logic              busy_i,
  output logic              wr_o,
  output logic              mode_o,
  output logic [DATA_W-1:0] data_o,
  output logic              en_o,
  output logic              err_o
);

  localparam int unsigned C     = DATA_W / 2;
  localparam int unsigned IW    = $clog2(DATA_W);
  localparam int unsigned PW    = TUNE_W + 1;
  localparam int unsigned DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC =
    DIV_W'(CLK_DIV - 1);
  // Pend rises 3 clocks early so the IDLE load and ISSUE land
  // exactly 2^REFRESH_W clocks after the previous pattern ISSUE.
  localparam logic [REFRESH_W-1:0] REF_TC =
    REFRESH_W'((64'd1 << REFRESH_W) - 64'd3);
  localparam logic [2:0] TMO = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_e;

  state_e state_q, state_d;

  logic [7:0]           bright_q, bright_d;
  logic [DATA_W-1:0]    pat_q, pat_d;
  logic                 cfg_pend_q, cfg_pend_d;
  logic                 pat_pend_q, pat_pend_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 mode_q, mode_d;
  logic                 wr_q, wr_d;
  logic [2:0]           tmr_q, tmr_d;
  logic                 err_q, err_d;
  logic [REFRESH_W-1:0] ref_q, ref_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 en_q, en_d;

  logic signed [TUNE_W-1:0] sh;
  logic [PW-1:0]            pos;
  logic [DATA_W-1:0]        dec;

  // pos is one bit wider than tune so s+C cannot wrap before the clamp
  always_comb begin
    sh  = $signed(tune_i) >>> SHIFT;
    pos = {sh[TUNE_W-1], sh} + PW'(C);
    dec = '0;
    if (blank_i) begin
      dec = '0;
    end else if (sh == '0) begin
      dec[C-1] = 1'b1;
      dec[C]   = 1'b1;
    end else if (pos[PW-1]) begin
      dec[0] = 1'b1;
    end else if (pos > PW'(DATA_W - 1)) begin
      dec[DATA_W-1] = 1'b1;
    end else begin
      dec[pos[IW-1:0]] = 1'b1;
    end
  end

  always_comb begin
    div_d = (div_q == DIV_TC) ? '0 : div_q + DIV_W'(1);
    en_d  = (div_q == DIV_TC);
  end

  always_comb begin
    state_d    = state_q;
    bright_d   = bright_wr_i ? bright_i : bright_q;
    pat_d      = tune_wr_i ? dec : pat_q;
    cfg_pend_d = cfg_pend_q;
    pat_pend_d = pat_pend_q;
    data_d     = data_q;
    mode_d     = mode_q;
    wr_d       = 1'b0;
    tmr_d      = tmr_q;
    err_d      = err_q;
    ref_d      = ref_q + REFRESH_W'(1);
    unique case (state_q)
      IDLE: begin
        if (!busy_i && cfg_pend_q) begin
          data_d     = {(DATA_W/8){bright_q}};
          mode_d     = 1'b1;
          cfg_pend_d = 1'b0;
          state_d    = ISSUE;
        end else if (!busy_i && pat_pend_q) begin
          data_d     = pat_q;
          mode_d     = 1'b0;
          pat_pend_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wr_d    = 1'b1;
        tmr_d   = '0;
        state_d = WAIT_HI;
        if (!mode_q) ref_d = '0;
      end
      WAIT_HI: begin
        if (busy_i) begin
          state_d = WAIT_LO;
        end else if (tmr_q == TMO) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 3'd1;
        end
      end
      WAIT_LO: begin
        if (!busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // new requests win over the clear of a load in the same clock
    if (ref_q == REF_TC) pat_pend_d = 1'b1;
    if (tune_wr_i)       pat_pend_d = 1'b1;
    if (bright_wr_i)     cfg_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bright_q   <= BRIGHT_INIT;
      pat_q      <= '0;
      cfg_pend_q <= 1'b1;
      pat_pend_q <= 1'b1;
      data_q     <= '0;
      mode_q     <= 1'b0;
      wr_q       <= 1'b0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      ref_q      <= '0;
      div_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bright_q   <= bright_d;
      pat_q      <= pat_d;
      cfg_pend_q <= cfg_pend_d;
      pat_pend_q <= pat_pend_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      wr_q       <= wr_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      ref_q      <= ref_d;
      div_q      <= div_d;
      en_q       <= en_d;
    end
  end

  assign wr_o   = wr_q;
  assign mode_o = mode_q;
  assign data_o = data_q;
  assign en_o   = en_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_tuner_led_ctrl.sv
// tb_tuner_led_ctrl: table vectors, random tuning words against a
// behavioural LED-bar model, and handshake/refresh corner sequences.
module tb_tuner_led_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst = 1'b1;
  logic [15:0] tune = '0;
  logic        tune_wr = 1'b0;
  logic        blank = 1'b0;
  logic [7:0]  bright = '0;
  logic        bright_wr = 1'b0;
  logic        busy;
  logic        wr, mode, en, err;
  logic [23:0] data;

  logic        rst_b = 1'b1;
  logic [15:0] tune_b = '0;
  logic        tune_wr_b = 1'b0;
  logic        blank_b = 1'b0;
  logic [7:0]  bright_b = '0;
  logic        bright_wr_b = 1'b0;
  logic        busy_b;
  logic        wr_b, mode_b, en_b, err_b;
  logic [23:0] data_b;

  tuner_led_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .tune_i(tune), .tune_wr_i(tune_wr),
    .blank_i(blank),
    .bright_i(bright), .bright_wr_i(bright_wr),
    .busy_i(busy),
    .wr_o(wr), .mode_o(mode), .data_o(data),
    .en_o(en), .err_o(err)
  );

  tuner_led_ctrl #(.REFRESH_W(6)) dut_r (
    .clk_i(clk), .rst_i(rst_b),
    .tune_i(tune_b), .tune_wr_i(tune_wr_b),
    .blank_i(blank_b),
    .bright_i(bright_b), .bright_wr_i(bright_wr_b),
    .busy_i(busy_b),
    .wr_o(wr_b), .mode_o(mode_b), .data_o(data_b),
    .en_o(en_b), .err_o(err_b)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // LED bar from the tuning rule: floor(t/16) steps off centre
  function automatic logic [23:0] model(input logic [15:0] t,
                                        input logic b);
    int v, s, idx;
    logic [23:0] one;
    one = 24'd1;
    v = int'($signed(t));
    s = v / 16;
    if (v < 0 && (v % 16) != 0) s = s - 1;
    if (b) return 24'd0;
    if (s == 0) return (one << 11) | (one << 12);
    idx = s + 12;
    if (idx < 0) idx = 0;
    if (idx > 23) idx = 23;
    return one << idx;
  endfunction

  bit busy_en = 1'b1;
  int bdly = 3;
  int blen = 60;

  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (wr && busy_en) begin
        repeat (bdly) @(negedge clk);
        busy = 1'b1;
        repeat (blen) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  initial begin
    busy_b = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_b) begin
        repeat (2) @(negedge clk);
        busy_b = 1'b1;
        repeat (4) @(negedge clk);
        busy_b = 1'b0;
      end
    end
  end

  typedef struct {
    logic        mode;
    logic [23:0] data;
    int          cyc;
  } wr_t;

  wr_t  wrq[$];
  wr_t  wbq[$];
  int   enq[$];
  logic wr_p = 1'b0;
  bit   err_seen = 1'b0;
  int   err_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (wr) begin
        chk("wr_one_clock", {31'd0, wr_p}, 32'd0);
        wrq.push_back('{mode, data, cyc});
      end
      wr_p = wr;
      if (wr_b) wbq.push_back('{mode_b, data_b, cyc});
      if (en_b) enq.push_back(cyc);
      if (rst) begin
        err_seen = 1'b0;
      end else if (err && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
    end
  end

  task automatic get_wr(input bit sel, input int budget,
                        input string nm, output wr_t w);
    int n;
    bit ok;
    n = 0;
    while (((sel ? wbq.size() : wrq.size()) == 0)
           && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (sel ? wbq.size() : wrq.size()) != 0;
    chk({nm, "_seen"}, {31'd0, ok}, 32'd1);
    if (ok) w = sel ? wbq.pop_front() : wrq.pop_front();
    else    w = '{1'bx, 24'hxxxxxx, -1000};
  endtask

  task automatic send_tune(input logic [15:0] t,
                           input logic b, output int t0);
    @(negedge clk);
    tune = t;
    blank = b;
    tune_wr = 1'b1;
    t0 = cyc;
    @(negedge clk);
    tune_wr = 1'b0;
    blank = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] t;
    logic        b;
    logic [23:0] e;
    string       nm;
  } vec_t;

  initial begin
    vec_t tbl[13];
    wr_t  w, w1, w2;
    int   t0, r0, cnt;
    logic [15:0] rt;
    logic rb;

    tbl[0]  = '{16'h0000, 1'b0, 24'h001800, "centre"};
    tbl[1]  = '{16'h0010, 1'b0, 24'h002000, "plus1"};
    tbl[2]  = '{16'hFFF0, 1'b0, 24'h000800, "minus1"};
    tbl[3]  = '{16'h7FFF, 1'b0, 24'h800000, "max_pos"};
    tbl[4]  = '{16'h8000, 1'b0, 24'h000001, "max_neg"};
    tbl[5]  = '{16'h0000, 1'b1, 24'h000000, "blank"};
    tbl[6]  = '{16'h000F, 1'b0, 24'h001800, "sub_step"};
    tbl[7]  = '{16'hFFFF, 1'b0, 24'h000800, "neg_lsb"};
    tbl[8]  = '{16'h00BF, 1'b0, 24'h800000, "top_edge"};
    tbl[9]  = '{16'hFF40, 1'b0, 24'h000001, "bot_edge"};
    tbl[10] = '{16'hFF30, 1'b0, 24'h000001, "bot_clamp"};
    tbl[11] = '{16'h00A0, 1'b0, 24'h400000, "step10"};
    tbl[12] = '{16'h7FFF, 1'b1, 24'h000000, "blank_max"};

    settle(3);
    chk("rst_wr",   {31'd0, wr},   32'd0);
    chk("rst_mode", {31'd0, mode}, 32'd0);
    chk("rst_data", {8'd0, data},  32'd0);
    chk("rst_en",   {31'd0, en},   32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    rst = 1'b0;

    get_wr(0, 200, "boot_cfg", w);
    chk("boot_cfg_mode", {31'd0, w.mode}, 32'd1);
    chk("boot_cfg_data", {8'd0, w.data}, 32'hFFFFFF);
    get_wr(0, 200, "boot_pat", w);
    chk("boot_pat_mode", {31'd0, w.mode}, 32'd0);
    chk("boot_pat_data", {8'd0, w.data}, 32'd0);
    settle(200);
    chk("boot_no_extra", wrq.size(), 32'd0);

    blen = 5;
    for (int i = 0; i < 13; i++) begin
      send_tune(tbl[i].t, tbl[i].b, t0);
      get_wr(0, 50, tbl[i].nm, w);
      chk({tbl[i].nm, "_data"}, {8'd0, w.data},
          {8'd0, tbl[i].e});
      chk({tbl[i].nm, "_mode"}, {31'd0, w.mode}, 32'd0);
      chk({tbl[i].nm, "_lat"}, w.cyc - t0, 32'd3);
      settle(15);
    end

    @(negedge clk);
    bright = 8'h3C;
    bright_wr = 1'b1;
    tune = 16'd32;
    tune_wr = 1'b1;
    @(negedge clk);
    bright_wr = 1'b0;
    tune_wr = 1'b0;
    get_wr(0, 50, "both_cfg", w);
    chk("both_cfg_mode", {31'd0, w.mode}, 32'd1);
    chk("both_cfg_data", {8'd0, w.data}, 32'h3C3C3C);
    get_wr(0, 50, "both_pat", w);
    chk("both_pat_mode", {31'd0, w.mode}, 32'd0);
    chk("both_pat_data", {8'd0, w.data}, 32'h004000);
    settle(15);

    blen = 20;
    send_tune(16'd0, 1'b0, t0);
    get_wr(0, 50, "coal_first", w);
    chk("coal_first_data", {8'd0, w.data}, 32'h001800);
    settle(5);
    send_tune(16'd16, 1'b0, t0);
    send_tune(16'd48, 1'b0, t0);
    send_tune(16'hFFD0, 1'b0, t0);
    get_wr(0, 100, "coal", w);
    chk("coal_data", {8'd0, w.data}, 32'h000200);
    chk("coal_mode", {31'd0, w.mode}, 32'd0);
    settle(60);
    chk("coal_single", wrq.size(), 32'd0);

    for (int i = 0; i < 25; i++) begin
      bdly = $urandom_range(1, 3);
      blen = $urandom_range(1, 8);
      if (i % 2 == 0) rt = 16'($urandom);
      else rt = 16'($urandom_range(0, 511) - 256);
      rb = ($urandom_range(0, 7) == 0);
      send_tune(rt, rb, t0);
      get_wr(0, 50, "rand", w);
      chk("rand_data", {8'd0, w.data},
          {8'd0, model(rt, rb)});
      chk("rand_mode", {31'd0, w.mode}, 32'd0);
      settle(bdly + blen + 8);
    end

    bdly = 3;
    blen = 5;
    busy_en = 1'b0;
    send_tune(16'd16, 1'b0, t0);
    get_wr(0, 50, "to_first", w1);
    chk("to_first_data", {8'd0, w1.data}, 32'h002000);
    send_tune(16'hFFF0, 1'b0, t0);
    for (int i = 0; i < 30 && !err_seen; i++) begin
      @(negedge clk);
      #1;
    end
    chk("to_err_seen", {31'd0, err_seen}, 32'd1);
    chk("to_err_delay", err_cyc - w1.cyc, 32'd7);
    get_wr(0, 50, "to_next", w2);
    chk("to_next_data", {8'd0, w2.data}, 32'h000800);
    chk("to_next_gap", w2.cyc - w1.cyc, 32'd9);
    settle(20);
    busy_en = 1'b1;
    send_tune(16'd0, 1'b0, t0);
    get_wr(0, 50, "after_to", w);
    settle(15);
    chk("err_sticky", {31'd0, err}, 32'd1);

    blen = 20;
    send_tune(16'd48, 1'b0, t0);
    get_wr(0, 50, "mid", w);
    chk("mid_data", {8'd0, w.data}, 32'h008000);
    settle(5);
    rst = 1'b1;
    settle(2);
    chk("mid_rst_wr",   {31'd0, wr},   32'd0);
    chk("mid_rst_data", {8'd0, data},  32'd0);
    chk("mid_rst_err",  {31'd0, err},  32'd0);
    rst = 1'b0;
    get_wr(0, 100, "re_cfg", w);
    chk("re_cfg_mode", {31'd0, w.mode}, 32'd1);
    chk("re_cfg_data", {8'd0, w.data}, 32'hFFFFFF);
    get_wr(0, 100, "re_pat", w);
    chk("re_pat_data", {8'd0, w.data}, 32'd0);
    settle(40);

    @(negedge clk);
    rst_b = 1'b0;
    r0 = cyc;
    settle(88);
    cnt = 0;
    foreach (enq[i]) if (enq[i] <= r0 + 87) cnt++;
    chk("en_count", cnt, 32'd10);
    if (enq.size() >= 10) begin
      chk("en_first", enq[0] - r0, 32'd8);
      for (int i = 1; i < 10; i++)
        chk("en_gap", enq[i] - enq[i-1], 32'd8);
    end
    settle(2);
    chk("ref_boot_cnt", wbq.size(), 32'd3);
    if (wbq.size() >= 3) begin
      chk("ref_cfg_mode", {31'd0, wbq[0].mode}, 32'd1);
      chk("ref_pat_data", {8'd0, wbq[1].data}, 32'd0);
      chk("ref_rep_data", {8'd0, wbq[2].data}, 32'd0);
      chk("ref_rep_gap", wbq[2].cyc - wbq[1].cyc, 32'd64);
    end
    wbq.delete();
    @(negedge clk);
    tune_b = 16'd32;
    tune_wr_b = 1'b1;
    @(negedge clk);
    tune_wr_b = 1'b0;
    get_wr(1, 50, "ref_new", w1);
    chk("ref_new_data", {8'd0, w1.data}, 32'h004000);
    for (int i = 0; i < 2; i++) begin
      get_wr(1, 100, "ref", w2);
      chk("ref_data", {8'd0, w2.data}, 32'h004000);
      chk("ref_mode", {31'd0, w2.mode}, 32'd0);
      chk("ref_gap", w2.cyc - w1.cyc, 32'd64);
      w1 = w2;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
